// File: rtl/isa_pkg.sv
// Shared ISA types for the fetch front end.
// The top-level fetch_queue honours the FETCH_BYPASS_EN macro (empty-queue bypass).
package isa_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: storage, wrapping read/write pointers, occupancy and synchronous clear.
// Empty reads return zero so the head outputs are clean without extra masking.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;
    assign rdata   = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch PC, push/pop qualification, redirect and a prefetch FIFO.
// Define FETCH_BYPASS_EN to forward a hit straight to decode when the queue is empty.
module fetch_queue
    import isa_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              iren,
    output logic [DATA_W-1:0] imemaddr,
    input  logic              ihit,
    input  logic [DATA_W-1:0] imemload,
    input  logic [DATA_W-1:0] pc_prediction,
    input  logic              misprediction,
    input  logic [DATA_W-1:0] correct_pc,
    input  logic              flush,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] pc,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int unsigned ENTRY_W = 2 * DATA_W;

    logic [DATA_W-1:0]  fetch_pc_q;
    logic [DATA_W-1:0]  fetch_pc_d;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] tail_entry;
    logic               fifo_empty;
    logic               fifo_full;
    logic               clear;
    logic               push_req;
    logic               fifo_push;
    logic               fifo_pop;
    logic               bypass;

    assign clear    = misprediction || flush;
    assign iren     = !fifo_full && !RST;
    assign imemaddr = fetch_pc_q;
    assign push_req = iren && ihit && !clear;

`ifdef FETCH_BYPASS_EN
    assign bypass = push_req && fifo_empty && instr_ready;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push  = push_req && !bypass;
    assign fifo_pop   = !fifo_empty && instr_ready && !clear;
    assign tail_entry = {fetch_pc_q, imemload};

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .clear (clear),
        .push  (fifo_push),
        .wdata (tail_entry),
        .pop   (fifo_pop),
        .rdata (head_entry),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (occupancy)
    );

    always_comb begin
        instr_valid = !fifo_empty;
        pc          = head_entry[ENTRY_W-1:DATA_W];
        instr       = head_entry[DATA_W-1:0];
        if (bypass) begin
            instr_valid = 1'b1;
            pc          = fetch_pc_q;
            instr       = imemload;
        end
    end

    // Redirect beats everything; flush freezes the PC; otherwise advance only on an accepted hit.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (misprediction) begin
            fetch_pc_d = correct_pc;
        end else if (push_req) begin
            fetch_pc_d = pc_prediction;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

endmodule
